// File: rtl/uart_pkt_loader_if.sv
// uart_pkt_loader_if: byte-stream and memory-write bundle for uart_pkt_loader.
//   rx_data/rx_valid           received byte strobe (no backpressure)
//   tx_data/tx_valid/tx_ready  status byte handshake
//   mem_we/mem_addr/mem_din    one-hot channel write port
// slave: the loader side. master: the environment (uart_rx/uart_tx/memories).
interface uart_pkt_loader_if #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned ADDR_W     = 32
) ();
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [N_CH-1:0]         mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [8*WORD_BYTES-1:0] mem_din;

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, mem_we, mem_addr, mem_din
  );

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/uart_pkt_loader.sv
// uart_pkt_loader: parses a checksummed command stream from the UART receiver,
// writes words into one of N_CH memories, controls the core run enable and
// returns a one-byte status on the transmit stream.
//   clk, reset  clock, synchronous active-high reset
//   io_bus      rx byte strobe, tx status handshake, memory write port
//   o_run       core run enable
//   o_busy      a packet is being parsed
module uart_pkt_loader #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RUN_DELAY  = 100,
  parameter int unsigned TIMEOUT    = 50000000
) (
  input  logic                    clk,
  input  logic                    reset,
  uart_pkt_loader_if.slave        io_bus,
  output logic                    o_run,
  output logic                    o_busy
);

  localparam int unsigned DW      = 8 * WORD_BYTES;
  localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);
  localparam logic [2:0]  WbLast  = 3'(WORD_BYTES - 1);
  localparam logic [31:0] RunLoad = 32'(RUN_DELAY);

  localparam logic [7:0] RspOk    = 8'hA5;
  localparam logic [7:0] RspCsum  = 8'hE1;
  localparam logic [7:0] RspChan  = 8'hE2;
  localparam logic [7:0] RspTmo   = 8'hE3;
  localparam logic [7:0] RspOpc   = 8'hE4;

  typedef enum logic [2:0] {StIdle, StAddr, StCnt, StData, StCsum} state_e;

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_idx, w_idx_nxt;
  logic [23:0]       r_shift, w_shift_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;
  logic [5:0]        r_ch, w_ch_nxt;
  logic [7:0]        r_sum, w_sum_nxt;
  logic [DW-1:0]     r_word, w_word_nxt, w_asm;
  logic [31:0]       r_tmo, w_tmo_nxt;
  logic [N_CH-1:0]   r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_maddr, w_maddr_nxt;
  logic [DW-1:0]     r_mdin, w_mdin_nxt;
  logic              r_txv, w_txv_nxt;
  logic [7:0]        r_txd, w_txd_nxt;
  logic              r_run, w_run_nxt;
  logic              r_run_arm, w_run_arm_nxt;
  logic [31:0]       r_run_cnt, w_run_cnt_nxt;
  logic              w_resp_vld, w_run_cmd, w_stop_cmd, w_ch_ok;
  logic [7:0]        w_resp;

  assign w_ch_ok = ({1'b0, r_ch} < 7'(N_CH));

  // Packet parser
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_sum_nxt   = r_sum;
    w_word_nxt  = r_word;
    w_tmo_nxt   = r_tmo;
    w_we_nxt    = '0;
    w_maddr_nxt = r_maddr;
    w_mdin_nxt  = r_mdin;
    w_resp_vld  = 1'b0;
    w_resp      = 8'h00;
    w_run_cmd   = 1'b0;
    w_stop_cmd  = 1'b0;
    w_asm       = r_word;
    w_asm[{r_idx, 3'b000} +: 8] = io_bus.rx_data;

    // An incoming byte in the expiry cycle takes priority over the abort.
    if (r_state != StIdle) begin
      if (io_bus.rx_valid) begin
        w_tmo_nxt = '0;
      end else if (r_tmo == TmoLast) begin
        w_state_nxt = StIdle;
        w_resp_vld  = 1'b1;
        w_resp      = RspTmo;
      end else begin
        w_tmo_nxt = r_tmo + 32'd1;
      end
    end

    if (io_bus.rx_valid) begin
      w_sum_nxt   = r_sum + io_bus.rx_data;
      w_shift_nxt = {io_bus.rx_data, r_shift[23:8]};
      unique case (r_state)
        StIdle: begin
          w_sum_nxt = io_bus.rx_data;
          w_tmo_nxt = '0;
          w_idx_nxt = '0;
          case (io_bus.rx_data[7:6])
            2'd0: begin
              w_state_nxt = StAddr;
              w_ch_nxt    = io_bus.rx_data[5:0];
              w_stop_cmd  = 1'b1;
            end
            2'd1: begin
              w_run_cmd  = 1'b1;
              w_resp_vld = 1'b1;
              w_resp     = RspOk;
            end
            2'd2: begin
              w_stop_cmd = 1'b1;
              w_resp_vld = 1'b1;
              w_resp     = RspOk;
            end
            default: begin
              w_resp_vld = 1'b1;
              w_resp     = RspOpc;
            end
          endcase
        end
        StAddr: begin
          w_idx_nxt = r_idx + 3'd1;
          if (r_idx == 3'd3) begin
            w_state_nxt = StCnt;
            w_idx_nxt   = '0;
            w_addr_nxt  = ADDR_W'({io_bus.rx_data, r_shift});
          end
        end
        StCnt: begin
          if (r_idx == 3'd0) begin
            w_idx_nxt = 3'd1;
          end else begin
            w_cnt_nxt   = {io_bus.rx_data, r_shift[23:16]};
            w_state_nxt = StData;
            w_idx_nxt   = '0;
          end
        end
        StData: begin
          w_word_nxt = w_asm;
          if (r_idx == WbLast) begin
            w_idx_nxt   = '0;
            w_we_nxt    = w_ch_ok ? (N_CH'(1) << r_ch) : '0;
            w_maddr_nxt = r_addr;
            w_mdin_nxt  = w_asm;
            w_addr_nxt  = r_addr + ADDR_W'(1);
            if (r_cnt == 16'd0) begin
              w_state_nxt = StCsum;
            end else begin
              w_cnt_nxt = r_cnt - 16'd1;
            end
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
        StCsum: begin
          w_state_nxt = StIdle;
          w_resp_vld  = 1'b1;
          if (!w_ch_ok) begin
            w_resp = RspChan;
          end else if (io_bus.rx_data == r_sum) begin
            w_resp = RspOk;
          end else begin
            w_resp = RspCsum;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // Run control and single-entry response register
  always_comb begin
    w_run_nxt     = r_run;
    w_run_arm_nxt = r_run_arm;
    w_run_cnt_nxt = r_run_cnt;
    // Counter loaded with RUN_DELAY; run is set on the edge after it reads 1.
    if (r_run_arm) begin
      if (r_run_cnt == 32'd1) begin
        w_run_nxt     = 1'b1;
        w_run_arm_nxt = 1'b0;
      end else begin
        w_run_cnt_nxt = r_run_cnt - 32'd1;
      end
    end
    if (w_stop_cmd) begin
      w_run_nxt     = 1'b0;
      w_run_arm_nxt = 1'b0;
      w_run_cnt_nxt = '0;
    end else if (w_run_cmd && !r_run) begin
      if (RUN_DELAY == 0) begin
        w_run_nxt = 1'b1;
      end else begin
        w_run_arm_nxt = 1'b1;
        w_run_cnt_nxt = RunLoad;
      end
    end

    w_txv_nxt = r_txv && !io_bus.tx_ready;
    w_txd_nxt = r_txd;
    // A response finding the slot still occupied is dropped.
    if (w_resp_vld && !w_txv_nxt) begin
      w_txv_nxt = 1'b1;
      w_txd_nxt = w_resp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_ch      <= '0;
      r_sum     <= '0;
      r_word    <= '0;
      r_tmo     <= '0;
      r_we      <= '0;
      r_maddr   <= '0;
      r_mdin    <= '0;
      r_txv     <= 1'b0;
      r_txd     <= '0;
      r_run     <= 1'b0;
      r_run_arm <= 1'b0;
      r_run_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ch      <= w_ch_nxt;
      r_sum     <= w_sum_nxt;
      r_word    <= w_word_nxt;
      r_tmo     <= w_tmo_nxt;
      r_we      <= w_we_nxt;
      r_maddr   <= w_maddr_nxt;
      r_mdin    <= w_mdin_nxt;
      r_txv     <= w_txv_nxt;
      r_txd     <= w_txd_nxt;
      r_run     <= w_run_nxt;
      r_run_arm <= w_run_arm_nxt;
      r_run_cnt <= w_run_cnt_nxt;
    end
  end

  assign io_bus.mem_we   = r_we;
  assign io_bus.mem_addr = r_maddr;
  assign io_bus.mem_din  = r_mdin;
  assign io_bus.tx_valid = r_txv;
  assign io_bus.tx_data  = r_txd;
  assign o_run           = r_run;
  assign o_busy          = (r_state != StIdle);

endmodule

// File: doc/uart_pkt_loader.md
# uart_pkt_loader

Packet-framed byte-stream loader for the core's memories and run control. It replaces switch-selected, fixed 32-bit insn/data loading with a command protocol over the UART receive byte stream:
- any of N_CH memory channels, WORD_BYTES-wide words, explicit start address and length;
- per-packet checksum and an inter-byte timeout;
- a one-byte status response on the transmit byte stream.

It sits between uart_rx/uart_tx and the core's memory write ports and run input.

## Interface
Parameters:
- N_CH, 2: number of memory channels (1..64).
- WORD_BYTES, 4: bytes per memory word (1..8).
- ADDR_W, 32: word-address width (≤32).
- RUN_DELAY, 100: cycles from RUN command to run=1.
- TIMEOUT, 50000000: idle cycles inside a packet before abort.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe per received byte; no backpressure.
- tx_data  out  8  status byte.
- tx_valid  out  1  status byte available.
- tx_ready  in  1  transmitter accepts; byte consumed when tx_valid&&tx_ready.
- mem_we  out  N_CH  one-hot write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_din  out  8*WORD_BYTES  word, first received byte in [7:0].
- run  out  1  core run enable.
- busy  out  1  packet in progress (state≠IDLE).

## Operation
Packet format. All multi-byte fields are little-endian. csum = 8-bit sum of every packet byte including cmd.
- cmd byte: [7:6] opcode, [5:0] channel.
- Opcode 0, WRITE: cmd, addr (4 bytes), cnt (2 bytes, words−1), (cnt+1)×WORD_BYTES payload bytes, csum byte.
- Opcode 1, RUN: cmd only.
- Opcode 2, STOP: cmd only.
- Opcode 3: reserved, treated as unknown.

State machine: IDLE → ADDR (4 bytes) → CNT (2 bytes) → DATA → CSUM → IDLE.
- RUN/STOP complete in IDLE.
- addr bits above ADDR_W are ignored.
- WRITE with channel ≥ N_CH is parsed fully (no writes) and answered 0xE2.
- In DATA, bytes shift into a word buffer. When the WORD_BYTES-th byte of a word arrives:
  - the mem_we bit for the channel pulses;
  - mem_addr takes the current address, mem_din the assembled word;
  - the address then increments mod 2^ADDR_W.
- In CSUM, the received byte is compared to the running sum. Response is 0xA5 on match, else 0xE1. Writes already done are not rolled back.

Run control:
- RUN: loads a countdown with RUN_DELAY; run=1 when it reaches 0.
- RUN while run=1: no effect.
- STOP: run=0 and countdown cleared on the next cycle.
- Any WRITE cmd byte forces run=0, as in STOP.
- Response 0xA5 for both RUN and STOP.
- Unknown opcode: response 0xE4, stay in IDLE.

Timeout: in any state ≠IDLE, TIMEOUT consecutive cycles without rx_valid abort to IDLE with response 0xE3. The counter reloads on every rx_valid.

Response register: single entry.
- tx_valid holds until tx_ready.
- A new response arriving while one is pending is dropped; the pending byte is kept.
- Parsing never stalls on tx.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_din=0, tx_valid=0, tx_data=0, run=0, busy=0; state=IDLE; timeout and run counters cleared.
- Reset mid-packet: packet discarded, no response.
- mem_we: registered, high for exactly one cycle, the cycle after the rx_valid of the word's last byte. mem_addr and mem_din are valid in that cycle and held until the next write.
- Response: tx_valid rises the cycle after the rx_valid of the final packet byte. For timeout, it rises the cycle after the counter expires.
- run: rises RUN_DELAY+1 cycles after the RUN cmd rx_valid cycle (RUN_DELAY=0 gives 1 cycle).
- rx_valid in the same cycle as timeout expiry: the byte wins, no abort.
- Back-to-back rx_valid on consecutive cycles: must be accepted.

## Test plan
- WRITE ch1, addr 0x10, cnt 1, payload 01..08, correct csum, WORD_BYTES=4 -> mem_we=2'b10 twice, (0x10, 0x04030201) then (0x11, 0x08070605); tx_data=0xA5.
- Same packet with csum+1 -> both writes occur; tx_data=0xE1.
- WRITE ch 5 with N_CH=2 -> no mem_we; full packet consumed; tx_data=0xE2.
- ADDR_W=4, addr 0xF, cnt 1 -> writes to 0xF then 0x0.
- RUN with RUN_DELAY=100 -> run=1 exactly 101 cycles after cmd strobe; STOP -> run=0 next cycle; WRITE cmd while running -> run=0.
- TIMEOUT=1000, stop sending after 3 addr bytes -> after 1000 idle cycles busy=0, tx_data=0xE3. Then hold tx_ready=0 and send a RUN -> 0xE3 stays pending and the RUN response is dropped.
